// File: rtl/audio_voice_mixer4_pkg.sv
// Shared definitions for the four-voice synthesizer core.
// Holds the default sample width, the offset-binary midscale, the
// waveform-select bit indices and the noise LFSR definition (seed, taps
// and a step function).
package audio_voice_mixer4_pkg;

    localparam int BITDEPTH = 14;
    localparam logic [13:0] MIDSCALE = 14'h2000;

    // Bit positions inside a voice_select mask
    localparam int SEL_TRI   = 0;
    localparam int SEL_SAW   = 1;
    localparam int SEL_PULSE = 2;
    localparam int SEL_NOISE = 3;

    // 23-bit Fibonacci noise generator
    localparam int          LFSR_WIDTH  = 23;
    localparam logic [22:0] LFSR_SEED   = 23'h7FFFFF;
    localparam int          LFSR_TAP_HI = 22;
    localparam int          LFSR_TAP_LO = 17;

    // Phase bit whose rising transition clocks the noise generator
    localparam int NOISE_CLK_BIT = 19;

    // One shift-left step with XOR feedback into bit 0
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        lfsr_next = {s[LFSR_WIDTH-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/audio_voice_mixer4_voice.sv
// One synthesizer voice: phase accumulator, noise LFSR and waveform select.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   tick_i           sample strobe; phase/LFSR advance only when high
//   increment_i      unsigned phase increment per sample
//   voice_select_i   waveform mask (tri, saw, pulse, noise); set bits are ANDed
//   osc_o            combinational offset-binary voice sample
module audio_voice #(
    parameter int BITDEPTH  = audio_voice_mixer4_pkg::BITDEPTH,
    parameter int ACC_WIDTH = 24,
    parameter int INC_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_i,
    input  logic [INC_WIDTH-1:0] increment_i,
    input  logic [3:0]           voice_select_i,
    output logic [BITDEPTH-1:0]  osc_o
);
    import audio_voice_mixer4_pkg::*;

    localparam logic [BITDEPTH-1:0] MID_L = {1'b1, {(BITDEPTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0]  phase_q, phase_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

    logic [BITDEPTH-1:0] tri_s, saw_s, pulse_s, noise_s, wave_s;

    // Next phase / LFSR: advance on the sample strobe, noise steps on a 0->1 of the clocking bit
    always_comb begin
        phase_d = phase_q;
        lfsr_d  = lfsr_q;
        if (tick_i) begin
            phase_d = phase_q + ACC_WIDTH'(increment_i);
            if (!phase_q[NOISE_CLK_BIT] && phase_d[NOISE_CLK_BIT]) begin
                lfsr_d = lfsr_next(lfsr_q);
            end else begin
                lfsr_d = lfsr_q;
            end
        end else begin
            phase_d = phase_q;
            lfsr_d  = lfsr_q;
        end
    end

    // Phase and LFSR state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Triangle folds the lower half-cycle ramp back down once the MSB sets
    assign tri_s   = phase_q[ACC_WIDTH-1] ? ~phase_q[ACC_WIDTH-2 -: BITDEPTH]
                                          :  phase_q[ACC_WIDTH-2 -: BITDEPTH];
    assign saw_s   = phase_q[ACC_WIDTH-1 -: BITDEPTH];
    assign pulse_s = phase_q[ACC_WIDTH-1] ? {BITDEPTH{1'b0}} : {BITDEPTH{1'b1}};
    assign noise_s = lfsr_q[LFSR_WIDTH-1 -: BITDEPTH];

    // Unselected waveforms contribute all-ones so they drop out of the AND
    assign wave_s = (voice_select_i[SEL_TRI]   ? tri_s   : {BITDEPTH{1'b1}})
                  & (voice_select_i[SEL_SAW]   ? saw_s   : {BITDEPTH{1'b1}})
                  & (voice_select_i[SEL_PULSE] ? pulse_s : {BITDEPTH{1'b1}})
                  & (voice_select_i[SEL_NOISE] ? noise_s : {BITDEPTH{1'b1}});

    assign osc_o = (voice_select_i == 4'b0000) ? MID_L : wave_s;

endmodule

// File: rtl/audio_voice_mixer4.sv
// Four-voice synthesizer core.
// A free-running divider produces a one-clk sample strobe every
// 2**SAMPLECLOCK_DIV clocks; four voices advance on that strobe and the
// mixer averages them into one offset-binary sample one clock later.
// Ports:
//   clk, rst_n                     system clock, asynchronous active-low reset
//   increment1..4                  per-voice phase increment
//   voice_select1..4               per-voice waveform mask
//   sample_tick                    one-clk strobe per sample period
//   osc1_out..osc4_out             per-voice samples (valid the clk after sample_tick)
//   mix                            averaged sample, updated 2 clk after sample_tick
module audio_voice_mixer4 #(
    parameter int BITDEPTH        = audio_voice_mixer4_pkg::BITDEPTH,
    parameter int SAMPLECLOCK_DIV = 8,
    parameter int ACC_WIDTH       = 24,
    parameter int INC_WIDTH       = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INC_WIDTH-1:0] increment1,
    input  logic [INC_WIDTH-1:0] increment2,
    input  logic [INC_WIDTH-1:0] increment3,
    input  logic [INC_WIDTH-1:0] increment4,
    input  logic [3:0]           voice_select1,
    input  logic [3:0]           voice_select2,
    input  logic [3:0]           voice_select3,
    input  logic [3:0]           voice_select4,
    output logic                 sample_tick,
    output logic [BITDEPTH-1:0]  osc1_out,
    output logic [BITDEPTH-1:0]  osc2_out,
    output logic [BITDEPTH-1:0]  osc3_out,
    output logic [BITDEPTH-1:0]  osc4_out,
    output logic [BITDEPTH-1:0]  mix
);
    import audio_voice_mixer4_pkg::*;

    localparam logic [BITDEPTH-1:0] MID_L = {1'b1, {(BITDEPTH-1){1'b0}}};

    logic [SAMPLECLOCK_DIV-1:0] cnt_q, cnt_d;
    logic                       tick_q, tick_d;
    logic                       tick_dly_q;
    logic [BITDEPTH-1:0]        mix_q, mix_d;

    logic signed [BITDEPTH+1:0] sum_s;
    logic [1:0]                 unused_frac_s;

    // Divider: the strobe register is loaded as the counter reaches all-ones,
    // so it is high exactly while the counter holds all-ones
    always_comb begin
        cnt_d  = cnt_q + {{(SAMPLECLOCK_DIV-1){1'b0}}, 1'b1};
        tick_d = (cnt_d == {SAMPLECLOCK_DIV{1'b1}});
    end

    // Divider, strobe and strobe-delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            tick_dly_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            tick_dly_q <= tick_q;
        end
    end

    assign sample_tick = tick_q;

    audio_voice #(.BITDEPTH(BITDEPTH), .ACC_WIDTH(ACC_WIDTH), .INC_WIDTH(INC_WIDTH)) u_voice1 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_q),
        .increment_i(increment1), .voice_select_i(voice_select1), .osc_o(osc1_out)
    );
    audio_voice #(.BITDEPTH(BITDEPTH), .ACC_WIDTH(ACC_WIDTH), .INC_WIDTH(INC_WIDTH)) u_voice2 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_q),
        .increment_i(increment2), .voice_select_i(voice_select2), .osc_o(osc2_out)
    );
    audio_voice #(.BITDEPTH(BITDEPTH), .ACC_WIDTH(ACC_WIDTH), .INC_WIDTH(INC_WIDTH)) u_voice3 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_q),
        .increment_i(increment3), .voice_select_i(voice_select3), .osc_o(osc3_out)
    );
    audio_voice #(.BITDEPTH(BITDEPTH), .ACC_WIDTH(ACC_WIDTH), .INC_WIDTH(INC_WIDTH)) u_voice4 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_q),
        .increment_i(increment4), .voice_select_i(voice_select4), .osc_o(osc4_out)
    );

    // Removing midscale from an offset-binary value is the same as flipping its MSB;
    // the result is then sign-extended to the wide accumulator
    function automatic logic signed [BITDEPTH+1:0] centred(input logic [BITDEPTH-1:0] x);
        centred = {{3{~x[BITDEPTH-1]}}, x[BITDEPTH-2:0]};
    endfunction

    assign sum_s = centred(osc1_out) + centred(osc2_out) + centred(osc3_out) + centred(osc4_out);

    // Taking bits [BITDEPTH+1:2] is the floor shift by 2; flipping the MSB adds midscale back
    always_comb begin
        if (tick_dly_q) begin
            mix_d = {~sum_s[BITDEPTH+1], sum_s[BITDEPTH:2]};
        end else begin
            mix_d = mix_q;
        end
    end

    assign unused_frac_s = sum_s[1:0];

    // Mix output register: loaded once per sample period, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_q <= MID_L;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix = mix_q;

endmodule

// File: tb/tb_audio_voice_mixer4.sv
// Self-checking bench for audio_voice_mixer4: a behavioural model tracks
// phases as integers modulo 2**24 and derives every waveform and the mix
// arithmetically.
module tb_audio_voice_mixer4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [20:0] inc_a [4];
    logic [3:0]  sel_a [4];
    logic        tick;
    logic [13:0] osc1, osc2, osc3, osc4, mix;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = 0;
    int exp_gap = 255;
    int m_phase [4];
    int m_lfsr  [4];

    audio_voice_mixer4 dut (
        .clk(clk), .rst_n(rst_n),
        .increment1(inc_a[0]), .increment2(inc_a[1]),
        .increment3(inc_a[2]), .increment4(inc_a[3]),
        .voice_select1(sel_a[0]), .voice_select2(sel_a[1]),
        .voice_select3(sel_a[2]), .voice_select4(sel_a[3]),
        .sample_tick(tick),
        .osc1_out(osc1), .osc2_out(osc2), .osc3_out(osc3), .osc4_out(osc4),
        .mix(mix)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] osc_val(input int i);
        case (i)
            0: osc_val = osc1;
            1: osc_val = osc2;
            2: osc_val = osc3;
            default: osc_val = osc4;
        endcase
    endfunction

    function automatic int exp_osc(input int i);
        int p, base, t, s, pu, n, r;
        p    = m_phase[i];
        s    = (p / 1024) % 16384;
        base = (p / 512) % 16384;
        t    = (p >= 8388608) ? (16383 - base) : base;
        pu   = (p >= 8388608) ? 0 : 16383;
        n    = (m_lfsr[i] / 512) % 16384;
        r    = 16383;
        if (sel_a[i][0]) r = r & t;
        if (sel_a[i][1]) r = r & s;
        if (sel_a[i][2]) r = r & pu;
        if (sel_a[i][3]) r = r & n;
        if (sel_a[i] == 4'd0) r = 8192;
        return r;
    endfunction

    // Average of the four offset-binary samples, rounded toward minus infinity
    function automatic int exp_mix();
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += exp_osc(i);
        return s / 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0;
            m_lfsr[i]  = 8388607;
        end
    endtask

    task automatic model_tick();
        int old_p, new_p, l;
        for (int i = 0; i < 4; i++) begin
            old_p = m_phase[i];
            new_p = (old_p + int'(inc_a[i])) % 16777216;
            if (((old_p / 524288) % 2 == 0) && ((new_p / 524288) % 2 == 1)) begin
                l = m_lfsr[i];
                m_lfsr[i] = ((l * 2) % 8388608) | (((l / 4194304) ^ (l / 131072)) & 1);
            end
            m_phase[i] = new_p;
        end
    endtask

    task automatic set_all(input logic [20:0] inc, input logic [3:0] sel);
        for (int i = 0; i < 4; i++) begin
            inc_a[i] = inc;
            sel_a[i] = sel;
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (hold) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        last_cyc = cyc;
        exp_gap = 255;
    endtask

    // Waits (bounded) for the strobe and checks its spacing from the previous one
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 600);
        tests++;
        if (tick !== 1'b1 || (cyc - last_cyc) != exp_gap) begin
            fails++;
            $display("FAIL tick_gap: got %0d clk (tick=%b), want %0d", cyc - last_cyc, tick, exp_gap);
        end
        last_cyc = cyc;
        exp_gap = 256;
    endtask

    // One sample period: strobe, then voices one clk later, then mix one clk after that
    task automatic do_tick();
        wait_tick();
        model_tick();
        @(negedge clk);
        tests++;
        if (tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: tick=%b one clk after strobe, want 0", tick);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (osc_val(i) !== 14'(exp_osc(i))) begin
                fails++;
                $display("FAIL osc%0d: got %h want %h (phase %h)", i + 1, osc_val(i), 14'(exp_osc(i)), m_phase[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (mix !== 14'(exp_mix())) begin
            fails++;
            $display("FAIL mix: got %h want %h", mix, 14'(exp_mix()));
        end
    endtask

    task automatic test_reset();
        inc_a[0] = 21'd0; inc_a[1] = 21'd0; inc_a[2] = 21'd0; inc_a[3] = 21'd0;
        sel_a[0] = 4'b0010; sel_a[1] = 4'b0001; sel_a[2] = 4'b0100; sel_a[3] = 4'b1000;
        repeat (3) @(negedge clk);
        tests++;
        if (mix !== 14'h2000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_mix_tick: mix=%h tick=%b want 2000/0", mix, tick);
        end
        tests++;
        if (osc1 !== 14'h0000 || osc2 !== 14'h0000 || osc3 !== 14'h3FFF || osc4 !== 14'h3FFF) begin
            fails++;
            $display("FAIL reset_osc: %h %h %h %h want 0000 0000 3fff 3fff", osc1, osc2, osc3, osc4);
        end
        model_reset();
        rst_n = 1'b1;
        last_cyc = cyc;
        exp_gap = 255;
        repeat (10) @(negedge clk);
        tests++;
        if (mix !== 14'h2000) begin
            fails++;
            $display("FAIL premix: got %h want 2000", mix);
        end
    endtask

    task automatic test_tick_timing();
        repeat (3) do_tick();
    endtask

    task automatic test_saw();
        set_all(21'd1024, 4'b0010);
        for (int n = 1; n <= 6; n++) begin
            do_tick();
            tests++;
            if (osc1 !== 14'(n) || mix !== 14'(n)) begin
                fails++;
                $display("FAIL saw_ramp: osc1=%h mix=%h want %h", osc1, mix, 14'(n));
            end
        end
    endtask

    task automatic test_triangle();
        do_reset(2);
        set_all(21'd512, 4'b0001);
        for (int n = 1; n <= 4; n++) begin
            do_tick();
            tests++;
            if (osc2 !== 14'(n)) begin
                fails++;
                $display("FAIL tri_up: got %h want %h", osc2, 14'(n));
            end
        end
        // Jump ahead so the phase MSB sets and the fold is exercised
        set_all(21'h100000, 4'b0001);
        repeat (10) do_tick();
    endtask

    task automatic test_pulse_silence();
        do_reset(2);
        inc_a[0] = 21'h100000; sel_a[0] = 4'b0100;
        for (int i = 1; i < 4; i++) begin
            inc_a[i] = 21'($urandom_range(0, 21'h1FFFFF));
            sel_a[i] = 4'b0000;
        end
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            tests++;
            if (k < 8) begin
                if (osc1 !== 14'h3FFF || mix !== 14'h27FF) begin
                    fails++;
                    $display("FAIL pulse_high: osc1=%h mix=%h want 3fff/27ff", osc1, mix);
                end
            end else begin
                if (osc1 !== 14'h0000 || mix !== 14'h1800) begin
                    fails++;
                    $display("FAIL pulse_low: osc1=%h mix=%h want 0000/1800", osc1, mix);
                end
            end
        end
    endtask

    task automatic test_wrap_combine();
        logic [13:0] prev_noise;
        int changes;
        do_reset(2);
        set_all(21'h1FFFFF, 4'b1100);
        sel_a[1] = 4'b1000;
        sel_a[3] = 4'b1111;
        prev_noise = osc2;
        changes = 0;
        for (int k = 0; k < 20; k++) begin
            do_tick();
            if (m_phase[0] >= 8388608) begin
                tests++;
                if (osc1 !== 14'h0000) begin
                    fails++;
                    $display("FAIL pulse_and_noise: osc1=%h want 0000 when phase msb set", osc1);
                end
            end
            if (osc2 !== prev_noise) changes++;
            prev_noise = osc2;
        end
        tests++;
        if (changes == 0) begin
            fails++;
            $display("FAIL noise_stuck: noise output changed %0d times, want >0", changes);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 4; i++) begin
                inc_a[i] = 21'($urandom_range(0, 21'h1FFFFF));
                sel_a[i] = 4'($urandom_range(0, 15));
            end
            do_tick();
        end
    endtask

    task automatic test_midreset();
        set_all(21'd12345, 4'b0010);
        do_tick();
        do_tick();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (mix !== 14'h2000 || tick !== 1'b0 || osc1 !== 14'h0000 || osc4 !== 14'h0000) begin
            fails++;
            $display("FAIL midreset: mix=%h tick=%b osc1=%h osc4=%h want 2000/0/0000/0000", mix, tick, osc1, osc4);
        end
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        last_cyc = cyc;
        exp_gap = 255;
        do_tick();
        do_tick();
    endtask

    initial begin
        test_reset();
        test_tick_timing();
        test_saw();
        test_triangle();
        test_pulse_silence();
        test_wrap_combine();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
